// File: rtl/seven_seg_reader.sv
// Reads back a pair of active-low 7-segment glyphs as a 6-bit value.
// Debounces by stability count and hands new values over valid/ack.
module seven_seg_reader #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [6:0] HEX_HI,
  input  logic [6:0] HEX_LO,
  output logic [5:0] value,
  output logic       valid,
  input  logic       ack,
  output logic       glyph_err,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_HIT =
    CNT_W'(STABLE_CYCLES - 1);

  logic [13:0]      s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stb_q, stb_d;
  logic [13:0]      last_q, last_d;
  logic             last_v_q, last_v_d;
  logic [5:0]       value_q, value_d;
  logic             valid_q, valid_d;
  logic             gerr_q, gerr_d;
  logic             ovr_q, ovr_d;

  logic [13:0] in_w;
  logic        same;
  logic        fire;
  logic        lo_ok, hi_ok;
  logic [3:0]  lo_val;
  logic [1:0]  hi_val;

  assign in_w = {HEX_HI, HEX_LO};
  assign same = (in_w == s_q);

  always_comb begin
    lo_ok  = 1'b1;
    lo_val = 4'h0;
    unique case (s_q[6:0])
      7'h40:   lo_val = 4'h0;
      7'h79:   lo_val = 4'h1;
      7'h24:   lo_val = 4'h2;
      7'h30:   lo_val = 4'h3;
      7'h19:   lo_val = 4'h4;
      7'h12:   lo_val = 4'h5;
      7'h02:   lo_val = 4'h6;
      7'h78:   lo_val = 4'h7;
      7'h00:   lo_val = 4'h8;
      7'h10:   lo_val = 4'h9;
      7'h08:   lo_val = 4'hA;
      7'h03:   lo_val = 4'hB;
      7'h46:   lo_val = 4'hC;
      7'h21:   lo_val = 4'hD;
      7'h06:   lo_val = 4'hE;
      7'h0E:   lo_val = 4'hF;
      default: lo_ok  = 1'b0;
    endcase
  end

  // A blank high digit reads as zero; the "0" glyph is not legal there.
  always_comb begin
    hi_ok  = 1'b1;
    hi_val = 2'd0;
    unique case (s_q[13:7])
      7'h7F:   hi_val = 2'd0;
      7'h79:   hi_val = 2'd1;
      7'h24:   hi_val = 2'd2;
      7'h30:   hi_val = 2'd3;
      default: hi_ok  = 1'b0;
    endcase
  end

  always_comb begin
    s_d   = in_w;
    cnt_d = cnt_q;
    if (!same) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    stb_d = same && (cnt_q == CNT_HIT);
  end

  // s_q is unchanged on the cycle after stb_q is set, so it still holds
  // the stable pattern here.
  assign fire = stb_q && (!last_v_q || (s_q != last_q));

  always_comb begin
    last_d   = last_q;
    last_v_d = last_v_q;
    value_d  = value_q;
    valid_d  = valid_q && !ack;
    gerr_d   = gerr_q;
    ovr_d    = ovr_q;
    if (fire) begin
      last_d   = s_q;
      last_v_d = 1'b1;
      if (lo_ok && hi_ok) begin
        value_d = {hi_val, lo_val};
        valid_d = 1'b1;
        if (valid_q && !ack) begin
          ovr_d = 1'b1;
        end
      end else begin
        gerr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s_q      <= 14'h3FFF;
      cnt_q    <= '0;
      stb_q    <= 1'b0;
      last_q   <= '0;
      last_v_q <= 1'b0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      gerr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      s_q      <= s_d;
      cnt_q    <= cnt_d;
      stb_q    <= stb_d;
      last_q   <= last_d;
      last_v_q <= last_v_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      gerr_q   <= gerr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign value     = value_q;
  assign valid     = valid_q;
  assign glyph_err = gerr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Bench for seven_seg_reader: scoreboard of presented values
// plus directed checks of latency, flags and handshake.
module tb_seven_seg_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] hex_hi;
  logic [6:0] hex_lo;
  logic [5:0] value;
  logic       valid;
  logic       ack;
  logic       glyph_err;
  logic       overrun;

  int passes = 0;
  int total  = 0;
  int exp_q[$];

  logic       pv   = 1'b0;
  logic [5:0] pval = '0;

  seven_seg_reader #(
    .STABLE_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .HEX_HI   (hex_hi),
    .HEX_LO   (hex_lo),
    .value    (value),
    .valid    (valid),
    .ack      (ack),
    .glyph_err(glyph_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [6:0] hi, input logic [6:0] lo);
    hex_hi = hi;
    hex_lo = lo;
  endtask

  task automatic wait_val(input logic [5:0] v, input string nm);
    int n = 0;
    while (!(valid && value == v) && n < 30) begin
      tick(1);
      n++;
    end
    chk(nm, int'(valid && value == v), 1);
  endtask

  task automatic ack_pulse(input string nm);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk(nm, int'(valid), 0);
  endtask

  // Monitor: every new presentation of a value is matched in order.
  always @(negedge clk) begin
    if (valid && (!pv || value != pval)) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL sb_unexpected: got %0d expected none", value);
      end else begin
        chk("sb_value", int'(value), exp_q.pop_front());
      end
    end
    pv   = valid;
    pval = value;
  end

  initial begin
    reset = 1'b1;
    ack   = 1'b0;
    present(7'h7F, 7'h7F);
    tick(2);
    chk("rst_valid", int'(valid), 0);
    chk("rst_value", int'(value), 0);
    chk("rst_gerr", int'(glyph_err), 0);
    chk("rst_ovr", int'(overrun), 0);

    // 03: latency after edge 5, single ack, no re-fire
    exp_q.push_back(3);
    present(7'h7F, 7'h30);
    reset = 1'b0;
    tick(5);
    chk("lat_early", int'(valid), 0);
    tick(1);
    chk("lat_valid", int'(valid), 1);
    chk("lat_value", int'(value), 3);
    ack_pulse("ack_drop3");
    tick(8);
    chk("no_refire", int'(valid), 0);

    // 2D and 3F
    exp_q.push_back(45);
    present(7'h24, 7'h21);
    wait_val(6'd45, "wait45");
    ack_pulse("ack_drop45");
    exp_q.push_back(63);
    present(7'h30, 7'h0E);
    wait_val(6'd63, "wait63");
    ack_pulse("ack_drop63");

    // glitch back to the last accepted pattern
    exp_q.push_back(0);
    present(7'h7F, 7'h40);
    wait_val(6'd0, "wait0");
    ack_pulse("ack_drop0");
    present(7'h7F, 7'h79);
    tick(2);
    present(7'h7F, 7'h40);
    tick(10);
    chk("glitch_valid", int'(valid), 0);
    chk("glitch_gerr", int'(glyph_err), 0);

    // blank low digit
    present(7'h7F, 7'h7F);
    tick(8);
    chk("blank_gerr", int'(glyph_err), 1);
    chk("blank_valid", int'(valid), 0);

    // "0" glyph on the high digit
    reset = 1'b1;
    tick(1);
    chk("rst2_gerr", int'(glyph_err), 0);
    present(7'h40, 7'h40);
    reset = 1'b0;
    tick(8);
    chk("hi0_gerr", int'(glyph_err), 1);
    chk("hi0_valid", int'(valid), 0);

    // overrun: two values with no ack
    reset = 1'b1;
    tick(1);
    exp_q.push_back(1);
    present(7'h7F, 7'h79);
    reset = 1'b0;
    wait_val(6'd1, "wait1");
    chk("ovr_before", int'(overrun), 0);
    exp_q.push_back(32);
    present(7'h24, 7'h40);
    wait_val(6'd32, "wait32");
    chk("ovr_set", int'(overrun), 1);
    ack_pulse("ack_drop32");

    // ack on the same edge as a new accept
    reset = 1'b1;
    tick(1);
    exp_q.push_back(2);
    present(7'h7F, 7'h24);
    reset = 1'b0;
    wait_val(6'd2, "wait2");
    exp_q.push_back(3);
    present(7'h7F, 7'h30);
    tick(5);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("coin_valid", int'(valid), 1);
    chk("coin_value", int'(value), 3);
    chk("coin_ovr", int'(overrun), 0);
    ack_pulse("ack_drop_coin");

    // reset with valid and glyph_err both set
    present(7'h7F, 7'h7F);
    tick(8);
    chk("pre_gerr", int'(glyph_err), 1);
    exp_q.push_back(5);
    present(7'h7F, 7'h12);
    wait_val(6'd5, "wait5");
    reset = 1'b1;
    tick(1);
    chk("mid_valid", int'(valid), 0);
    chk("mid_value", int'(value), 0);
    chk("mid_gerr", int'(glyph_err), 0);
    chk("mid_ovr", int'(overrun), 0);
    exp_q.push_back(5);
    reset = 1'b0;
    tick(5);
    chk("refire_early", int'(valid), 0);
    tick(1);
    chk("refire_valid", int'(valid), 1);
    chk("refire_value", int'(value), 5);
    ack_pulse("ack_drop5");

    tick(2);
    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
